// File: rtl/clk_seq_pkg.sv
// Shared types and sizing helpers for the clock-enable sequencer and its
// per-channel dividers.
package clk_seq_pkg;

  localparam int DEF_DIV_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    LOAD,
    SETTLE,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic                 en;
    logic [DEF_DIV_W-1:0] div;
  } ch_cfg_t;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided clock-enable channel: a 0..div counter that strobes ce on wrap
// while active, with load/stop/activate hooks driven by the sequencer.
module clk_div_channel
  import clk_seq_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    load_i,
  input  logic    stop_i,
  input  logic    activate_i,
  input  ch_cfg_t cfg_i,
  output logic    ce_o,
  output logic    wrap_o,
  output logic    active_o
);

  ch_cfg_t              cfg_q, cfg_d;
  logic [DEF_DIV_W-1:0] cnt_q, cnt_d;
  logic                 active_q, active_d;
  logic                 ce_q, ce_d;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (active_q) begin
      cnt_d = (cnt_q == cfg_q.div) ? '0 : cnt_q + 1'b1;
    end
    if (stop_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end
    if (load_i) begin
      cfg_d    = cfg_i;
      cnt_d    = '0;
      active_d = 1'b0;
    end
    if (activate_i && cfg_q.en) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end
    // Strobe is computed from next state so ce_o itself is a flop output.
    ce_d = active_d && (cnt_d == cfg_d.div);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ce_q     <= ce_d;
    end
  end

  assign ce_o     = ce_q;
  assign wrap_o   = active_q && (cnt_q == cfg_q.div);
  assign active_o = active_q;

endmodule

// File: rtl/clk_enable_sequencer.sv
// Derives NUM_CH clock-enable strobes from one base clock and reconfigures
// one channel at a time, switching only on a period boundary plus a settle gap.
module clk_enable_sequencer
  import clk_seq_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DIV_W         = DEF_DIV_W,
  parameter int SETTLE_CYCLES = 16,
  parameter int CH_W          = clog2_min1(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic              cfg_en_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] active_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int               SET_W       = clog2_min1(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  // Reset asserts immediately but releases two base-clock edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  seq_state_e       state_q;
  logic [CH_W-1:0]  ch_q;
  ch_cfg_t          req_q;
  logic [SET_W-1:0] settle_q;
  logic             ready_q, busy_q, done_q;

  logic [NUM_CH-1:0] sel, ch_load, ch_stop, ch_act, wrap, active;
  logic              settle_last, tgt_active, tgt_wrap;

  assign settle_last = (settle_q == SETTLE_LAST);
  assign tgt_active  = |(sel & active);
  assign tgt_wrap    = |(sel & wrap);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel[c]     = (ch_q == CH_W'(c));
    assign ch_stop[c] = sel[c] && (state_q == QUIESCE) && wrap[c];
    assign ch_load[c] = sel[c] && (state_q == LOAD);
    assign ch_act[c]  = sel[c] && (state_q == SETTLE) && settle_last;

    clk_div_channel u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_n),
      .load_i     (ch_load[c]),
      .stop_i     (ch_stop[c]),
      .activate_i (ch_act[c]),
      .cfg_i      (req_q),
      .ce_o       (ce_o[c]),
      .wrap_o     (wrap[c]),
      .active_o   (active[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      req_q    <= '0;
      settle_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            ch_q    <= cfg_ch_i;
            // The request struct carries the package-default divider width.
            req_q   <= '{en: cfg_en_i, div: DEF_DIV_W'(cfg_div_i)};
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (int'(cfg_ch_i) < NUM_CH) begin
              state_q <= QUIESCE;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        QUIESCE: begin
          // An active target leaves only on its own strobe, so its last period is whole.
          if (!tgt_active || tgt_wrap) state_q <= LOAD;
        end
        LOAD: begin
          settle_q <= '0;
          if (req_q.en) begin
            state_q <= SETTLE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign active_o    = active;

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// Self-checking bench: request table, multi-cycle corner sequences and random
// requests, all compared every cycle against a timeline model of the sequencer.
module tb_clk_enable_sequencer;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int SETTLE = 16;
  localparam int CH_W   = 3;
  localparam longint INF = 64'd1 << 40;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_ready_o;
  logic [CH_W-1:0]   cfg_ch_i = '0;
  logic              cfg_en_i = 1'b0;
  logic [DIV_W-1:0]  cfg_div_i = '0;
  logic [NUM_CH-1:0] ce_o, active_o;
  logic              busy_o, done_o;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  clk_enable_sequencer #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SETTLE_CYCLES(SETTLE), .CH_W(CH_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i(cfg_ch_i), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .ce_o(ce_o), .active_o(active_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // Each channel runs a segment [seg_act, seg_off) with period div+1 measured
  // from seg_act; a request maps to a quiesce point q and a done cycle.
  bit     seg_on  [NUM_CH];
  longint seg_act [NUM_CH];
  longint seg_off [NUM_CH];
  int     seg_div [NUM_CH];
  bit     pend    [NUM_CH];
  longint pend_act[NUM_CH];
  int     pend_div[NUM_CH];
  bit     req_live;
  longint req_n, req_done;

  logic [NUM_CH-1:0] e_ce, e_act;
  logic              e_busy, e_done, e_ready;

  function automatic bit m_active(input int c, input longint t);
    return seg_on[c] && (t >= seg_act[c]) && (t < seg_off[c]);
  endfunction

  task automatic m_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      seg_on[c] = 1'b0;
      pend[c]   = 1'b0;
    end
    req_live = 1'b0;
  endtask

  task automatic m_register(input longint n);
    int     c, d;
    longint q, k;
    req_live = 1'b1;
    req_n    = n;
    if (int'(cfg_ch_i) >= NUM_CH) begin
      req_done = n;
    end else begin
      c = int'(cfg_ch_i);
      q = n;
      if (m_active(c, n)) begin
        d = seg_div[c];
        k = (n - seg_act[c]) % (d + 1);
        q = n + (d - k);
        seg_off[c] = q + 1;
      end
      if (cfg_en_i) begin
        pend[c]     = 1'b1;
        pend_act[c] = q + 2 + SETTLE;
        pend_div[c] = int'(cfg_div_i);
        req_done    = q + 2 + SETTLE;
      end else begin
        req_done = q + 2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_clear();
      e_ce = '0; e_act = '0; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend[c] && cyc >= pend_act[c]) begin
          seg_on[c]  = 1'b1;
          seg_act[c] = pend_act[c];
          seg_div[c] = pend_div[c];
          seg_off[c] = INF;
          pend[c]    = 1'b0;
        end
        e_act[c] = m_active(c, cyc);
        e_ce[c]  = e_act[c] && (((cyc - seg_act[c]) % (seg_div[c] + 1)) == seg_div[c]);
      end
      e_busy  = req_live && (cyc >= req_n) && (cyc <= req_done);
      e_done  = req_live && (cyc == req_done);
      e_ready = !e_busy;
    end
    check("cycle", {cfg_ready_o, busy_o, done_o, active_o, ce_o},
          {e_ready, e_busy, e_done, e_act, e_ce});
    if (rst_ni && cfg_valid_i && e_ready) m_register(cyc + 1);
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int                ch;
    bit                en;
    int                div;
    int                exp_lat;
    logic [NUM_CH-1:0] exp_act;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Returns at posedge+2 of the transfer cycle, or of the cycle after done.
  task automatic send(input int ch, input bit en, input int div, input bit wait_done,
                      output int lat, output logic [NUM_CH-1:0] act);
    bit got = 1'b0;
    lat = -1;
    act = '0;
    cfg_ch_i = CH_W'(ch); cfg_en_i = en; cfg_div_i = DIV_W'(div); cfg_valid_i = 1'b1;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      got = cfg_ready_o;
      step();
    end
    cfg_valid_i = 1'b0;
    cfg_ch_i = CH_W'($urandom); cfg_en_i = 1'($urandom); cfg_div_i = DIV_W'($urandom);
    check("accepted", 32'(got), 1);
    if (wait_done && got) begin
      for (int k = 0; k < 600; k++) begin
        @(negedge clk);
        if (done_o) begin
          lat = k;
          act = active_o;
          break;
        end
        step();
      end
      if (lat >= 0) step();
      check("done_seen", 32'(lat >= 0), 1);
    end
  endtask

  // Waits for done_o from the current cycle; returns at posedge+2 after it.
  task automatic wait_done_pulse(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      seen = done_o;
      step();
    end
  endtask

  initial begin
    vec_t tbl[7];
    int lat, miss, win_st, quiet_st, post, xfers, dones;
    logic [NUM_CH-1:0] act;
    bit seen, dropped, acc;
    longint lastce, drop, last_done;

    tbl[0] = '{ch: 0, en: 1, div: 3,   exp_lat: 18, exp_act: 4'b0001};
    tbl[1] = '{ch: 5, en: 1, div: 7,   exp_lat: 0,  exp_act: 4'b0001};
    tbl[2] = '{ch: 1, en: 0, div: 0,   exp_lat: 2,  exp_act: 4'b0001};
    tbl[3] = '{ch: 1, en: 1, div: 0,   exp_lat: 18, exp_act: 4'b0011};
    tbl[4] = '{ch: 2, en: 1, div: 9,   exp_lat: 18, exp_act: 4'b0111};
    tbl[5] = '{ch: 3, en: 1, div: 255, exp_lat: 18, exp_act: 4'b1111};
    tbl[6] = '{ch: 7, en: 0, div: 0,   exp_lat: 0,  exp_act: 4'b1111};

    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    repeat (3) step();
    check("reset_outputs", {cfg_ready_o, busy_o, done_o, active_o, ce_o}, 11'h400);
    rst_ni = 1'b1;
    repeat (4) step();
    check("idle_after_reset", {cfg_ready_o, busy_o, done_o, active_o, ce_o}, 11'h400);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].ch, tbl[i].en, tbl[i].div, 1'b1, lat, act);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_active", i), 32'(act), 32'(tbl[i].exp_act));
      step();
    end

    // ch0 div3 -> div1 while ch1 (div0) keeps strobing every cycle.
    send(0, 1'b1, 1, 1'b0, lat, act);
    miss = 0; win_st = 0; quiet_st = 0; dropped = 1'b0; seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (!ce_o[1]) miss++;
      if (ce_o[0]) win_st++;
      if (!active_o[0]) dropped = 1'b1;
      if (dropped && ce_o[0]) quiet_st++;
      seen = done_o;
      step();
    end
    check("reconf_done", 32'(seen), 1);
    check("ch1_every_cycle", 32'(miss), 0);
    check("ch0_window_strobes", 32'(win_st), 1);
    check("ch0_quiet_settle", 32'(quiet_st), 0);
    post = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ce_o[0]) post++;
      step();
    end
    check("ch0_period2", 32'(post), 4);

    // Disable running ch2 (div9): last strobe then drop the next cycle.
    send(2, 1'b0, 0, 1'b0, lat, act);
    lastce = -100; drop = -1; seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (ce_o[2]) lastce = cyc;
      if (!active_o[2] && drop < 0) drop = cyc;
      seen = done_o;
      step();
    end
    check("disable_done", 32'(seen), 1);
    check("ch2_drop_after_ce", 32'(drop - lastce), 1);
    post = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ce_o[2] || active_o[2]) post++;
      step();
    end
    check("ch2_silent", 32'(post), 0);

    // Three back-to-back requests with valid held high.
    begin
      int r_ch[3]  = '{3, 6, 1};
      bit r_en[3]  = '{1, 1, 0};
      int r_div[3] = '{4, 0, 0};
      int idx = 0;
      xfers = 0; dones = 0; last_done = 0;
      cfg_ch_i = CH_W'(r_ch[0]); cfg_en_i = r_en[0]; cfg_div_i = DIV_W'(r_div[0]);
      cfg_valid_i = 1'b1;
      for (int k = 0; k < 1500 && (xfers < 3 || dones < 3); k++) begin
        @(negedge clk);
        if (done_o) begin
          dones++;
          last_done = cyc;
        end
        acc = cfg_ready_o && cfg_valid_i;
        step();
        if (acc) begin
          xfers++;
          if (xfers > 1) check("b2b_gap", 32'(cyc - last_done), 2);
          idx++;
          if (idx < 3) begin
            cfg_ch_i = CH_W'(r_ch[idx]); cfg_en_i = r_en[idx]; cfg_div_i = DIV_W'(r_div[idx]);
          end else begin
            cfg_valid_i = 1'b0;
          end
        end
      end
      cfg_valid_i = 1'b0;
      check("b2b_transfers", 32'(xfers), 3);
      check("b2b_dones", 32'(dones), 3);
    end

    // Reset while ch1 is settling: in-flight request is dropped.
    send(1, 1'b1, 7, 1'b0, lat, act);
    repeat (5) step();
    rst_ni = 1'b0;
    #1;
    check("async_reset", {cfg_ready_o, busy_o, done_o, active_o, ce_o}, 11'h400);
    dones = 0;
    repeat (2) step();
    rst_ni = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done_o) dones++;
      step();
    end
    check("reset_no_done", 32'(dones), 0);
    check("post_reset_idle", {cfg_ready_o, busy_o, done_o, active_o, ce_o}, 11'h400);

    // Re-enable with identical divider, then random traffic.
    send(2, 1'b1, 5, 1'b1, lat, act);
    send(2, 1'b1, 5, 1'b1, lat, act);
    for (int i = 0; i < 24; i++) begin
      int rch  = int'($urandom_range(0, 5));
      bit ren  = ($urandom_range(0, 3) != 0);
      int rdiv = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12));
      send(rch, ren, rdiv, 1'b1, lat, act);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_done_pulse(seen);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_enable_sequencer.md
Name: clk_enable_sequencer

Overview:
- Owns one base clock and derives NUM_CH divided clock-enable strobes from it, one per consumer domain.
- Reconfigures one channel at a time (enable, disable, change divider) through a valid/ready config port.
- Each change is applied only at a safe point, followed by a settle window.
- Sits directly downstream of the simulation/base clock source; consumers gate their logic with ce_o instead of using separately generated clocks.

Parameters:
- NUM_CH, 4, number of clock-enable channels (≥1).
- DIV_W, 8, divider field width; channel period = div+1 base cycles.
- SETTLE_CYCLES, 16, base cycles a reconfigured channel stays silent before its first strobe (≥1).

Ports:
- clk_i  input  1  base clock.
- rst_ni  input  1  asynchronous active-low reset.
- cfg_valid_i  input  1  config request valid.
- cfg_ready_o  output  1  sequencer can accept a request.
- cfg_ch_i  input  $clog2(NUM_CH) (min 1)  target channel.
- cfg_en_i  input  1  1 = enable with cfg_div_i; 0 = disable.
- cfg_div_i  input  DIV_W  divider value; ignored when cfg_en_i=0.
- ce_o  output  NUM_CH  one-cycle clock-enable strobes.
- active_o  output  NUM_CH  channel enabled and settled.
- busy_o  output  1  sequencer not in IDLE.
- done_o  output  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (async assert, sync deassert, both handled inside): all channels disabled, counters 0, div regs 0.
  - Outputs: ce_o=0, active_o=0, busy_o=0, done_o=0, cfg_ready_o=1.
- Per channel: counter cnt counts 0..div and wraps to 0.
  - ce_o[c]=1 in a cycle where active_o[c]=1 and cnt==div (registered output).
  - div=0 gives ce every cycle; div=255 gives 1 in 256.
- Handshake:
  - Transfer when cfg_valid_i & cfg_ready_o; cfg_ready_o=1 only in IDLE.
  - Request fields are captured on transfer; inputs are don't-care afterwards.
  - cfg_ch_i ≥ NUM_CH: request accepted, no channel touched, done_o pulses 1 cycle after transfer (IDLE→DONE).
- FSM IDLE→QUIESCE→LOAD→SETTLE→DONE→IDLE:
  - QUIESCE: if target not active, leave next cycle. Else wait for the cycle target emits ce (cnt==div); active_o[target] drops the following cycle. No partial period is ever produced.
  - LOAD: write en/div to target, cnt=0. If en=0 go to DONE, else SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles with the target silent, then set active_o[target]=1 and go to DONE. First ce arrives div cycles after active rises (cnt starts 0 on activation).
  - DONE: done_o=1 for one cycle, then IDLE.
- Other channels run undisturbed throughout.
- Re-enable with the same div still goes through quiesce+settle.
- Disable of an inactive channel: QUIESCE 1 cycle, LOAD, DONE; no ce change.
- Reset mid-operation: everything returns to reset state immediately; the in-flight request is dropped with no done_o.
- valid held high in DONE/IDLE boundary: accepted first cycle back in IDLE.

Decomposition:
- Package clk_seq_pkg:
  - seq_state_e enum (IDLE, QUIESCE, LOAD, SETTLE, DONE).
  - ch_cfg_t struct {logic en; logic [DIV_W-1:0] div} with DIV_W default constant.
  - Helper function for settle counter width.
- Sub-module clk_div_channel, instantiated NUM_CH times:
  - Holds cnt/div/active and produces ce plus a wrap flag.
  - Takes load, stop and activate controls from the sequencer FSM.

Test Plan:
- Reset then enable ch0 div=3 → busy 1 for 1+1+16+1 cycles; active_o[0] rises after SETTLE; ce_o[0] every 4th cycle, first 3 cycles after active; done_o single pulse.
- ch0 running div=3, reconfigure to div=1 → old strobes stop only after a ce; no strobe during 16 settle cycles; then period 2; ch1 running div=0 strobes every cycle throughout.
- Disable active ch2 div=9 → last ce_o[2] in QUIESCE, active_o[2]=0 next cycle, no further ce; done_o pulses.
- cfg_valid held with 3 back-to-back requests → exactly 3 transfers, each only with cfg_ready_o=1, 3 done_o pulses, in order.
- Assert rst_ni low during SETTLE of ch1 → all outputs 0 asynchronously, cfg_ready_o=1 after release, no done_o.
- cfg_ch_i=5 with NUM_CH=4 (3-bit field override) → done_o 1 cycle after transfer, ce_o/active_o unchanged.
